regfile: RTL and testbench



---
 rtl/tiny16_pkg.sv | 17 +
 rtl/reg_counter.sv | 44 ++++
 rtl/regfile.sv | 118 +++++++++++
 tb/tb_regfile.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/tiny16_pkg.sv
// Shared tiny16 definitions: word and select widths, and the architectural register indices.
package tiny16_pkg;

    localparam int WORD_W    = 16;
    localparam int REG_SEL_W = 4;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [REG_SEL_W-1:0] reg_sel_t;

    localparam reg_sel_t REG_ZERO = 4'd0;
    localparam reg_sel_t REG_PC   = 4'd1;
    localparam reg_sel_t REG_SP   = 4'd2;
    localparam reg_sel_t REG_BA   = 4'd3;
    localparam reg_sel_t REG_RA   = 4'd4;
    localparam reg_sel_t REG_RES  = 4'd15;

endpackage

// File: rtl/reg_counter.sv
// Loadable up/down word counter. Load beats stepping, and inc with dec together hold the value.
// The wrap output flags that the coming edge steps across the 0000/FFFF boundary.
module reg_counter
    import tiny16_pkg::*;
#(
    parameter word_t INIT = '0
) (
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  word_t load_val,
    input  logic  inc,
    input  logic  dec,
    output word_t count,
    output logic  wrap
);

    logic step_up;
    logic step_dn;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        step_up = inc && !dec;
        step_dn = dec && !inc;
        wrap    = 1'b0;
        if (!load) begin
            wrap = (step_up && (count == '1)) || (step_dn && (count == '0));
        end
    end

    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= INIT;
        end else if (load) begin
            count <= load_val;
        end else if (step_up) begin
            count <= count + 1'b1;
        end else if (step_dn) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/regfile.sv
// tiny16 register file: r0 reads zero, r1/r2 are the PC/SP counters, r3..r15 plain storage.
// Optional macro STACK_GUARD_EN enables the sticky sp_fault stack-wrap flag.
module regfile
    import tiny16_pkg::*;
#(
    parameter word_t PC_INIT = 16'h0000,
    parameter word_t SP_INIT = 16'h0000
) (
    input  logic     clk,
    input  logic     rst,
    input  word_t    bus_in,
    input  reg_sel_t reg_src_sel,
    input  reg_sel_t reg_dst_sel,
    input  logic     reg_in_en,
    input  logic     reg_up_en,
    input  logic     reg_lo_en,
    input  logic     reg_pc_inc,
    input  logic     reg_sp_inc,
    input  logic     reg_sp_dec,
    input  logic     reg_out_en,
    output word_t    bus_out,
    output word_t    alu_a,
    output word_t    alu_b,
    output word_t    pc,
    output word_t    sp,
    output logic     sp_fault
);

    word_t gpr [REG_BA:REG_RES];
    word_t r_view [2**REG_SEL_W];
    word_t wr_data;
    word_t dst_cur;
    logic  wr_en;
    logic  pc_wrap;
    logic  sp_wrap;

    always_comb begin
        r_view[REG_ZERO] = '0;
        r_view[REG_PC]   = pc;
        r_view[REG_SP]   = sp;
        for (int i = REG_BA; i <= REG_RES; i++) begin
            r_view[i] = gpr[i];
        end
    end

    assign dst_cur = r_view[reg_dst_sel];
    assign wr_en   = (reg_in_en || reg_up_en || reg_lo_en) && (reg_dst_sel != REG_ZERO);

    // A full-word write wins; otherwise each byte strobe replaces its byte with bus_in[7:0].
    always_comb begin
        wr_data = dst_cur;
        if (reg_in_en) begin
            wr_data = bus_in;
        end else begin
            if (reg_up_en) wr_data[15:8] = bus_in[7:0];
            if (reg_lo_en) wr_data[7:0]  = bus_in[7:0];
        end
    end

    // NOTE: this small register array is architecturally reset, unlike a RAM macro.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = REG_BA; i <= REG_RES; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            for (int i = REG_BA; i <= REG_RES; i++) begin
                if (wr_en && (reg_dst_sel == reg_sel_t'(i))) begin
                    gpr[i] <= wr_data;
                end
            end
        end
    end

    reg_counter #(.INIT(PC_INIT)) u_pc (
        .clk      (clk),
        .rst      (rst),
        .load     (wr_en && (reg_dst_sel == REG_PC)),
        .load_val (wr_data),
        .inc      (reg_pc_inc),
        .dec      (1'b0),
        .count    (pc),
        .wrap     (pc_wrap)
    );

    reg_counter #(.INIT(SP_INIT)) u_sp (
        .clk      (clk),
        .rst      (rst),
        .load     (wr_en && (reg_dst_sel == REG_SP)),
        .load_val (wr_data),
        .inc      (reg_sp_inc),
        .dec      (reg_sp_dec),
        .count    (sp),
        .wrap     (sp_wrap)
    );

    assign bus_out = reg_out_en ? r_view[reg_src_sel] : '0;
    assign alu_a   = dst_cur;
    assign alu_b   = r_view[reg_src_sel];

`ifdef STACK_GUARD_EN
    logic unused_wrap;
    assign unused_wrap = pc_wrap;

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_fault <= 1'b0;
        end else if (sp_wrap) begin
            sp_fault <= 1'b1;
        end
    end
`else
    logic unused_wrap;
    assign unused_wrap = pc_wrap | sp_wrap;
    assign sp_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed vector table, hand sequences, then random traffic against a model.
module tb_regfile;

    localparam logic [15:0] PC_INIT = 16'h0100;
    localparam logic [15:0] SP_INIT = 16'h0000;
`ifdef STACK_GUARD_EN
    localparam logic GUARD = 1'b1;
`else
    localparam logic GUARD = 1'b0;
`endif

    typedef struct {
        logic        rst;
        logic [15:0] bus;
        logic [3:0]  src;
        logic [3:0]  dst;
        logic        in_en, up, lo, pci, spi, spd, oe;
        logic        chk;
        logic [15:0] e_bus, e_a, e_b, e_pc, e_sp;
        logic        e_f;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] bus_in;
    logic [3:0]  reg_src_sel, reg_dst_sel;
    logic        reg_in_en, reg_up_en, reg_lo_en;
    logic        reg_pc_inc, reg_sp_inc, reg_sp_dec, reg_out_en;
    logic [15:0] bus_out, alu_a, alu_b, pc, sp;
    logic        sp_fault;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m [16];
    logic        m_f;

    regfile #(.PC_INIT(PC_INIT), .SP_INIT(SP_INIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus_in     (bus_in),
        .reg_src_sel(reg_src_sel),
        .reg_dst_sel(reg_dst_sel),
        .reg_in_en  (reg_in_en),
        .reg_up_en  (reg_up_en),
        .reg_lo_en  (reg_lo_en),
        .reg_pc_inc (reg_pc_inc),
        .reg_sp_inc (reg_sp_inc),
        .reg_sp_dec (reg_sp_dec),
        .reg_out_en (reg_out_en),
        .bus_out    (bus_out),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .pc         (pc),
        .sp         (sp),
        .sp_fault   (sp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [15:0] b, input logic [3:0] s, input logic [3:0] d,
                                input logic i, input logic u, input logic l, input logic pi, input logic si,
                                input logic sd, input logic o, input logic c, input logic [15:0] eb,
                                input logic [15:0] ea, input logic [15:0] ebb, input logic [15:0] ep,
                                input logic [15:0] es, input logic ef);
        vec_t v;
        v.rst = r; v.bus = b; v.src = s; v.dst = d;
        v.in_en = i; v.up = u; v.lo = l; v.pci = pi; v.spi = si; v.spd = sd; v.oe = o;
        v.chk = c; v.e_bus = eb; v.e_a = ea; v.e_b = ebb; v.e_pc = ep; v.e_sp = es; v.e_f = ef;
        return v;
    endfunction

    function automatic logic [15:0] m_read(input logic [3:0] idx);
        return (idx == 4'd0) ? 16'h0000 : m[idx];
    endfunction

    // Reference behaviour: apply one clock edge of the architectural rules to the model.
    task automatic model_step(input vec_t v);
        logic [15:0] nxt [16];
        logic [15:0] val;
        int          written;
        int          delta;
        if (v.rst) begin
            foreach (m[i]) m[i] = 16'h0000;
            m[1] = PC_INIT;
            m[2] = SP_INIT;
            m_f  = 1'b0;
            return;
        end
        nxt = m;
        written = -1;
        if (v.dst != 4'd0 && (v.in_en || v.up || v.lo)) begin
            val = m[v.dst];
            if (v.in_en) val = v.bus;
            else begin
                if (v.up) val = {v.bus[7:0], val[7:0]};
                if (v.lo) val = {val[15:8], v.bus[7:0]};
            end
            nxt[v.dst] = val;
            written = int'(v.dst);
        end
        if (v.pci && written != 1) nxt[1] = 16'((int'(m[1]) + 1) % 65536);
        if (written != 2) begin
            delta = int'(v.spi) - int'(v.spd);
            nxt[2] = 16'((int'(m[2]) + delta + 65536) % 65536);
            if (GUARD && ((delta == 1 && m[2] == 16'hFFFF) || (delta == -1 && m[2] == 16'h0000)))
                m_f = 1'b1;
        end
        m = nxt;
    endtask

    task automatic apply(input vec_t v, input bit use_model);
        @(negedge clk);
        rst = v.rst; bus_in = v.bus; reg_src_sel = v.src; reg_dst_sel = v.dst;
        reg_in_en = v.in_en; reg_up_en = v.up; reg_lo_en = v.lo;
        reg_pc_inc = v.pci; reg_sp_inc = v.spi; reg_sp_dec = v.spd; reg_out_en = v.oe;
        #1;
        if (v.chk) begin
            check("vec bus_out", bus_out, v.e_bus);
            check("vec alu_a", alu_a, v.e_a);
            check("vec alu_b", alu_b, v.e_b);
            check("vec pc", pc, v.e_pc);
            check("vec sp", sp, v.e_sp);
            check("vec sp_fault", {15'd0, sp_fault}, {15'd0, v.e_f});
        end
        if (use_model) begin
            check("rnd bus_out", bus_out, v.oe ? m_read(v.src) : 16'h0000);
            check("rnd alu_a", alu_a, m_read(v.dst));
            check("rnd alu_b", alu_b, m_read(v.src));
            check("rnd pc", pc, m[1]);
            check("rnd sp", sp, m[2]);
            check("rnd sp_fault", {15'd0, sp_fault}, {15'd0, m_f});
        end
        @(posedge clk);
        model_step(v);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t v;
        rst = 1'b1; bus_in = '0; reg_src_sel = '0; reg_dst_sel = '0;
        reg_in_en = 0; reg_up_en = 0; reg_lo_en = 0;
        reg_pc_inc = 0; reg_sp_inc = 0; reg_sp_dec = 0; reg_out_en = 0;
        foreach (m[i]) m[i] = 16'h0000;
        m_f = 1'b0;

        //             rst bus      src dst in up lo pi si sd oe chk bus      a        b        pc       sp       f
        tbl.push_back(mk(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0000, 0));
        tbl.push_back(mk(0, 16'hABCD, 5, 5, 0, 0, 1, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0012, 5, 5, 0, 1, 0, 0, 0, 0, 1, 1, 16'h00CD, 16'h00CD, 16'h00CD, 16'h0100, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h1234, 5, 5, 0, 1, 1, 0, 0, 0, 1, 1, 16'h12CD, 16'h12CD, 16'h12CD, 16'h0100, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 5, 5, 0, 0, 0, 0, 0, 0, 1, 1, 16'h3434, 16'h3434, 16'h3434, 16'h0100, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h2000, 1, 1, 1, 0, 0, 1, 0, 0, 0, 1, 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h2000, 16'h2000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'hFFFF, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h2000, 16'h2000, 16'h2000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 2, 2, 0, 0, 0, 0, 0, 1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0));
        tbl.push_back(mk(0, 16'h0000, 2, 2, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, GUARD));
        tbl.push_back(mk(0, 16'h0000, 2, 2, 0, 0, 0, 0, 1, 1, 0, 1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, GUARD));
        tbl.push_back(mk(0, 16'h0000, 2, 2, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFF, GUARD));
        tbl.push_back(mk(0, 16'h5555, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, GUARD));
        tbl.push_back(mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, GUARD));
        tbl.push_back(mk(0, 16'h0040, 3, 3, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, GUARD));
        tbl.push_back(mk(0, 16'h0000, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0040, 16'h0000, 16'h0040, 16'h0000, 16'hFFFF, GUARD));
        tbl.push_back(mk(0, 16'h7777, 0, 7, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, GUARD));
        tbl.push_back(mk(1, 16'h1111, 7, 7, 1, 0, 0, 1, 0, 0, 1, 1, 16'h7777, 16'h7777, 16'h7777, 16'h0000, 16'hFFFF, GUARD));
        tbl.push_back(mk(0, 16'h0000, 7, 7, 0, 0, 0, 0, 0, 0, 1, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], 1'b0);

        // SP wrap upward via inc, then explicit SP writes keep the sticky flag and beat dec.
        apply(mk(0, 16'hFFFF, 2, 2, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, 0), 1'b0);
        apply(mk(0, 16'h0000, 2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 16'h0000, 16'h0000, 16'hFFFF, 16'h0100, 16'hFFFF, 0), 1'b0);
        apply(mk(0, 16'h0000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, GUARD), 1'b0);
        apply(mk(0, 16'h1234, 2, 2, 1, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0100, 16'h0000, GUARD), 1'b0);
        apply(mk(0, 16'h0000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h1234, 16'h0100, 16'h1234, GUARD), 1'b0);
        apply(mk(0, 16'h00AA, 2, 2, 0, 0, 1, 0, 0, 1, 0, 1, 16'h0000, 16'h1234, 16'h1234, 16'h0100, 16'h1234, GUARD), 1'b0);
        apply(mk(0, 16'h0000, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h12AA, 16'h0100, 16'h12AA, GUARD), 1'b0);

        // Random traffic; SP/PC are steered near the wrap points often enough to hit them.
        for (int n = 0; n < 2000; n++) begin
            v = mk(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);
            v.rst   = ($urandom_range(0, 99) == 0);
            v.bus   = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000)
                                                  : 16'($urandom);
            v.src   = 4'($urandom);
            v.dst   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom);
            v.in_en = ($urandom_range(0, 3) == 0);
            v.up    = ($urandom_range(0, 4) == 0);
            v.lo    = ($urandom_range(0, 4) == 0);
            v.pci   = ($urandom_range(0, 2) == 0);
            v.spi   = ($urandom_range(0, 2) == 0);
            v.spd   = ($urandom_range(0, 2) == 0);
            v.oe    = ($urandom_range(0, 1) == 1);
            apply(v, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
